lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-requester round-robin arbiter driving an HD44780-style
// LCD write bus (E, RS, data). Each granted write runs SETUP -> EHIGH -> HOLD
// under one 20-bit cycle counter and ends with a one-cycle ack to the owner.
// Optional feature macro: LCD_ARB_LOCK_EN adds lock0/lock1 inputs that let the
// current owner keep the bus across back-to-back writes (e.g. a full LCD row).
module lcd_bus_arbiter #(
   parameter int T_SETUP = 2,
   parameter int T_EH    = 50000,
   parameter int T_CYC   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
`ifdef LCD_ARB_LOCK_EN
   input  logic       lock0,
   input  logic       lock1,
`endif
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       E,
   output logic       RS,
   output logic [7:0] data
);

   typedef enum logic [1:0] {IDLE, SETUP, EHIGH, HOLD} state_t;

   // Counter values marking the last cycle of each phase.
   localparam logic [19:0] SETUP_LAST = 20'(T_SETUP - 1);
   localparam logic [19:0] EH_LAST    = 20'(T_SETUP + T_EH - 1);
   localparam logic [19:0] CYC_LAST   = 20'(T_CYC - 1);

   state_t      state_r, state_s;
   logic [19:0] cnt_r, cnt_s;
   logic        grant_r, grant_s;   // current / most recent owner (0 or 1)
   logic        rs_r, rs_s;
   logic [7:0]  data_r, data_s;
   logic        e_r, e_s;
   logic        busy_r, busy_s;
   logic        ack0_r, ack0_s;
   logic        ack1_r, ack1_s;
   logic        fire_s;
   logic        win_s;

   // Round-robin choice: on a tie the requester not served last wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
      logic pick;
      if (r0 && r1) begin
         pick = ~last;
      end else if (r1) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction

`ifdef LCD_ARB_LOCK_EN
   logic lock_hold_r;

   // Remember, for exactly the IDLE cycle after an ack, whether the owner asked to keep the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_hold_r <= 1'b0;
      end else if (state_r == HOLD && cnt_r == CYC_LAST) begin
         lock_hold_r <= grant_r ? lock1 : lock0;
      end else begin
         lock_hold_r <= 1'b0;
      end
   end

   // Winner selection: a locked owner still requesting is re-granted, else round-robin.
   always_comb begin
      win_s = rr_pick(req0, req1, grant_r);
      if (lock_hold_r && (grant_r ? req1 : req0)) begin
         win_s = grant_r;
      end else begin
         win_s = rr_pick(req0, req1, grant_r);
      end
   end
`else
   // Winner selection: pure round-robin.
   always_comb begin
      win_s = rr_pick(req0, req1, grant_r);
   end
`endif

   // Next-state, counter and bus-latch logic; outputs derive from the next state so they register in step.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      grant_s = grant_r;
      rs_s    = rs_r;
      data_s  = data_r;
      case (state_r)
         IDLE: begin
            cnt_s = 20'd0;
            if (req0 || req1) begin
               state_s = SETUP;
               grant_s = win_s;
               rs_s    = win_s ? rs1 : rs0;
               data_s  = win_s ? data1 : data0;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            cnt_s = cnt_r + 20'd1;
            if (cnt_r == SETUP_LAST) begin
               state_s = EHIGH;
            end else begin
               state_s = SETUP;
            end
         end
         EHIGH: begin
            cnt_s = cnt_r + 20'd1;
            if (cnt_r == EH_LAST) begin
               state_s = HOLD;
            end else begin
               state_s = EHIGH;
            end
         end
         HOLD: begin
            if (cnt_r == CYC_LAST) begin
               state_s = IDLE;
               cnt_s   = 20'd0;
            end else begin
               state_s = HOLD;
               cnt_s   = cnt_r + 20'd1;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 20'd0;
         end
      endcase

      e_s    = (state_s == EHIGH);
      busy_s = (state_s != IDLE);
      fire_s = (state_s == HOLD) && (cnt_s == CYC_LAST);
      ack0_s = fire_s && !grant_s;
      ack1_s = fire_s && grant_s;
   end

   // State, counter and registered bus/handshake outputs; reset drops E immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= 20'd0;
         grant_r <= 1'b1;
         rs_r    <= 1'b0;
         data_r  <= 8'h00;
         e_r     <= 1'b0;
         busy_r  <= 1'b0;
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         grant_r <= grant_s;
         rs_r    <= rs_s;
         data_r  <= data_s;
         e_r     <= e_s;
         busy_r  <= busy_s;
         ack0_r  <= ack0_s;
         ack1_r  <= ack1_s;
      end
   end

   assign E    = e_r;
   assign RS   = rs_r;
   assign data = data_r;
   assign busy = busy_r;
   assign ack0 = ack0_r;
   assign ack1 = ack1_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed self-checking bench for lcd_bus_arbiter with
// T_SETUP=1, T_EH=4, T_CYC=10. Cycle k counts rising edges after a stimulus
// point; outputs are sampled 1 time unit after each edge.
module tb_lcd_bus_arbiter;
   localparam int T_SETUP = 1;
   localparam int T_EH    = 4;
   localparam int T_CYC   = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       rs0 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
`ifdef LCD_ARB_LOCK_EN
   logic       lock0 = 1'b0, lock1 = 1'b0;
`endif
   logic       ack0, ack1, busy, E, RS;
   logic [7:0] data;

   int n_chk  = 0;
   int n_pass = 0;

   lcd_bus_arbiter #(.T_SETUP(T_SETUP), .T_EH(T_EH), .T_CYC(T_CYC)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
      .data0(data0), .data1(data1),
`ifdef LCD_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .ack0(ack0), .ack1(ack1), .busy(busy), .E(E), .RS(RS), .data(data)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_e", 8'(E), 8'd0);
      check("rst_rs", 8'(RS), 8'd0);
      check("rst_data", data, 8'h00);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_ack0", 8'(ack0), 8'd0);
      check("rst_ack1", 8'(ack1), 8'd0);
      rst = 1'b0;

      // Single write: E high cycles 2..5, ack0 at cycle 10, idle at 11
      rs0 = 1'b1; data0 = 8'h44; req0 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         check("t1_e", 8'(E), 8'((k >= 2) && (k <= 5)));
         check("t1_ack0", 8'(ack0), 8'(k == 10));
         check("t1_busy", 8'(busy), 8'(k <= 10));
         if (k == 1) begin
            check("t1_rs", 8'(RS), 8'd1);
            check("t1_data", data, 8'h44);
         end
         if (k == 10) req0 = 1'b0;
      end

      // Simultaneous requests after reset: 0, 1, 0 with acks 11 cycles apart
      rst = 1'b1; tick(); rst = 1'b0;
      rs0 = 1'b0; data0 = 8'h30; rs1 = 1'b1; data1 = 8'h31;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         tick();
         check("t2_ack0", 8'(ack0), 8'((k == 10) || (k == 32)));
         check("t2_ack1", 8'(ack1), 8'(k == 21));
         check("t2_busy", 8'(busy), 8'(!((k == 11) || (k == 22) || (k == 33))));
         if (k == 1 || k == 23) begin
            check("t2_data0", data, 8'h30);
            check("t2_rs0", 8'(RS), 8'd0);
         end
         if (k == 12) begin
            check("t2_data1", data, 8'h31);
            check("t2_rs1", 8'(RS), 8'd1);
         end
         if (k == 32) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end

      // Mid-write input change and req drop are ignored
      rs0 = 1'b0; data0 = 8'h38; req0 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         check("t3_e", 8'(E), 8'((k >= 2) && (k <= 5)));
         check("t3_ack0", 8'(ack0), 8'(k == 10));
         if (k <= 10) check("t3_data", data, 8'h38);
         if (k == 3) begin
            data0 = 8'hFF; req0 = 1'b0;
         end
      end
      check("t3_idle", 8'(busy), 8'd0);

      // Reset during EHIGH: E drops at once, no ack, clean restart
      rs1 = 1'b1; data1 = 8'h55; req1 = 1'b1;
      tick(); tick(); tick();
      check("t4_e_before", 8'(E), 8'd1);
      rst = 1'b1; req1 = 1'b0;
      #1;
      check("t4_e_async", 8'(E), 8'd0);
      check("t4_busy_async", 8'(busy), 8'd0);
      check("t4_data_async", data, 8'h00);
      tick(); rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("t4_noack1", 8'(ack1), 8'd0);
         check("t4_idle", 8'(busy), 8'd0);
      end
      rs1 = 1'b0; data1 = 8'h66; req1 = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         check("t4_e", 8'(E), 8'((k >= 2) && (k <= 5)));
         check("t4_ack1", 8'(ack1), 8'(k == 10));
         if (k == 1) begin
            check("t4_data", data, 8'h66);
            check("t4_rs", 8'(RS), 8'd0);
            check("t4_busy", 8'(busy), 8'd1);
         end
         if (k == 10) req1 = 1'b0;
      end

      // Idle bus holds last written RS/data
      for (int k = 1; k <= 50; k++) begin
         tick();
         check("t5_e", 8'(E), 8'd0);
         check("t5_busy", 8'(busy), 8'd0);
         check("t5_data", data, 8'h66);
         check("t5_rs", 8'(RS), 8'd0);
      end

`ifdef LCD_ARB_LOCK_EN
      // Lock: three requester-0 writes, then requester 1 after lock drops
      rs0 = 1'b1; data0 = 8'h41; rs1 = 1'b1; data1 = 8'h42;
      lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1;
      for (int k = 1; k <= 44; k++) begin
         tick();
         check("t6_ack0", 8'(ack0), 8'((k == 10) || (k == 21) || (k == 32)));
         check("t6_ack1", 8'(ack1), 8'(k == 43));
         if (k == 12 || k == 23) check("t6_data0", data, 8'h41);
         if (k == 34) check("t6_data1", data, 8'h42);
         if (k == 25) lock0 = 1'b0;
         if (k == 43) begin
            req0 = 1'b0; req1 = 1'b0;
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
